// File: rtl/rd_scoreboard_pkg.sv
// Shared register-address types for the register-read scoreboard.
package rd_scoreboard_pkg;

  localparam int RV_NUM_REGS = 32;
  localparam int RV_REG_AW   = 5;

  typedef logic [RV_REG_AW-1:0] t_rv_reg_addr;

endpackage : rd_scoreboard_pkg

// File: rtl/rd_scoreboard_sb_counter.sv
// Per-register pending-writer counter: up on issue, down on writeback, cleared on flush.
module sb_counter #(
  parameter int MAX = 3,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          nz
);

  localparam logic [CW-1:0] SAT = CW'(MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Simultaneous inc and dec cancel; clr wins over both.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != SAT) cnt_d = cnt_q + CW'(1);
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clr && dec && !inc) begin
      assert (cnt_q != '0) else $error("scoreboard underflow");
    end
  end

  assign cnt = cnt_q;
  assign nz  = (cnt_q != '0);

endmodule : sb_counter

// File: rtl/rd_scoreboard.sv
// RD0 register scoreboard: stalls uops whose sources are pending or whose destination is saturated.
module rd_scoreboard
  import rd_scoreboard_pkg::*;
#(
  parameter  int NUM_REGS     = RV_NUM_REGS,
  parameter  int MAX_INFLIGHT = 3,
  localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_de1,
  input  logic                src1_en_de1,
  input  t_rv_reg_addr        src1_addr_de1,
  input  logic                src2_en_de1,
  input  t_rv_reg_addr        src2_addr_de1,
  input  logic                dst_en_de1,
  input  t_rv_reg_addr        dst_addr_de1,
  input  logic                ext_stall,
  input  logic                wb_valid_rb1,
  input  t_rv_reg_addr        wb_addr_rb1,
  input  logic                br_mispred_rb1,
  output logic                stall_rd0,
  output logic                issue_rd0,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam logic [CW-1:0] SAT = CW'(MAX_INFLIGHT);

  logic [NUM_REGS-1:0][CW-1:0] cnt;
  logic [NUM_REGS-1:0]         nz;
  logic [NUM_REGS-1:0]         dst_oh;
  logic [NUM_REGS-1:0]         wb_oh;
  logic [NUM_REGS-1:0]         inc_vec;
  logic [NUM_REGS-1:0]         dec_vec;
  logic                        hazard;

  // x0 is hardwired zero: no counter, never busy.
  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(
      .MAX (MAX_INFLIGHT),
      .CW  (CW)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_vec[r]),
      .dec   (dec_vec[r]),
      .clr   (br_mispred_rb1),
      .cnt   (cnt[r]),
      .nz    (nz[r])
    );
  end

  // Hazard looks only at registered counts: no same-cycle writeback bypass.
  always_comb begin
    hazard = (src1_en_de1 && nz[src1_addr_de1])
          || (src2_en_de1 && nz[src2_addr_de1])
          || (dst_en_de1 && (dst_addr_de1 != '0) && (cnt[dst_addr_de1] == SAT));
  end

  assign stall_rd0 = valid_de1 && (hazard || ext_stall);
  assign issue_rd0 = valid_de1 && !stall_rd0 && !br_mispred_rb1;

  assign dst_oh  = NUM_REGS'(1) << dst_addr_de1;
  assign wb_oh   = NUM_REGS'(1) << wb_addr_rb1;
  assign inc_vec = (issue_rd0 && dst_en_de1) ? (dst_oh & ~NUM_REGS'(1)) : '0;
  assign dec_vec = wb_valid_rb1 ? (wb_oh & ~NUM_REGS'(1)) : '0;

  assign busy_vec = nz;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(issue_rd0 && stall_rd0)) else $error("issue while stalled");
      assert (!busy_vec[0]) else $error("x0 reported busy");
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!reset && !br_mispred_rb1) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r] && cnt[r] != SAT)
          $info("sb issue x%0d cnt=%0d", r, int'(cnt[r]) + 1);
        else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
          $info("sb writeback x%0d cnt=%0d", r, int'(cnt[r]) - 1);
      end
    end
  end
`endif

endmodule : rd_scoreboard

// File: tb/tb_rd_scoreboard.sv
// Directed scoreboard bench for rd_scoreboard: driver pushes expected outputs, monitor pops and compares.
module tb_rd_scoreboard;
  import rd_scoreboard_pkg::*;

  localparam int W = 34;  // {stall, issue, busy_vec[31:0]}

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_de1, src1_en_de1, src2_en_de1, dst_en_de1;
  t_rv_reg_addr src1_addr_de1, src2_addr_de1, dst_addr_de1, wb_addr_rb1;
  logic         ext_stall, wb_valid_rb1, br_mispred_rb1;
  logic         stall_rd0, issue_rd0;
  logic [31:0]  busy_vec;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  rd_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .valid_de1      (valid_de1),
    .src1_en_de1    (src1_en_de1),
    .src1_addr_de1  (src1_addr_de1),
    .src2_en_de1    (src2_en_de1),
    .src2_addr_de1  (src2_addr_de1),
    .dst_en_de1     (dst_en_de1),
    .dst_addr_de1   (dst_addr_de1),
    .ext_stall      (ext_stall),
    .wb_valid_rb1   (wb_valid_rb1),
    .wb_addr_rb1    (wb_addr_rb1),
    .br_mispred_rb1 (br_mispred_rb1),
    .stall_rd0      (stall_rd0),
    .issue_rd0      (issue_rd0),
    .busy_vec       (busy_vec)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, ".stall"}, {31'd0, stall_rd0}, {31'd0, e[33]});
      check({nm, ".issue"}, {31'd0, issue_rd0}, {31'd0, e[32]});
      check({nm, ".busy"},  busy_vec,          e[31:0]);
    end
  end

  task automatic idle_inputs();
    valid_de1 = 0; src1_en_de1 = 0; src1_addr_de1 = '0; src2_en_de1 = 0; src2_addr_de1 = '0;
    dst_en_de1 = 0; dst_addr_de1 = '0; ext_stall = 0; wb_valid_rb1 = 0; wb_addr_rb1 = '0;
    br_mispred_rb1 = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Driver: one cycle of stimulus plus the expected combinational outputs for that cycle.
  task automatic cyc(input string nm, input logic v,
                     input logic s1e, input int s1, input logic s2e, input int s2,
                     input logic de, input int d, input logic ext,
                     input logic wbv, input int wba, input logic mis,
                     input logic e_stall, input logic e_issue, input logic [31:0] e_busy);
    @(posedge clk); #1;
    valid_de1 = v;
    src1_en_de1 = s1e; src1_addr_de1 = t_rv_reg_addr'(s1);
    src2_en_de1 = s2e; src2_addr_de1 = t_rv_reg_addr'(s2);
    dst_en_de1  = de;  dst_addr_de1  = t_rv_reg_addr'(d);
    ext_stall = ext; wb_valid_rb1 = wbv; wb_addr_rb1 = t_rv_reg_addr'(wba); br_mispred_rb1 = mis;
    exp_q.push_back({e_stall, e_issue, e_busy});
    name_q.push_back(nm);
  endtask

  function automatic logic [31:0] b(input int r);
    return 32'd1 << r;
  endfunction

  initial begin
    idle_inputs();
    reset = 1'b1;
    do_reset(2);

    //   name          v  s1e s1 s2e s2 de d  ext wbv wba mis  stall issue busy
    cyc("reset",       0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,   0, 0, 32'd0);
    cyc("wr_x5",       1, 0, 0,  0, 0,  1, 5,  0, 0, 0,  0,   0, 1, 32'd0);
    cyc("rd_x5_wb",    1, 1, 5,  0, 0,  0, 0,  0, 1, 5,  0,   1, 0, b(5));
    cyc("rd_x5_go",    1, 1, 5,  0, 0,  0, 0,  0, 0, 0,  0,   0, 1, 32'd0);
    cyc("wr_x0",       1, 0, 0,  0, 0,  1, 0,  0, 0, 0,  0,   0, 1, 32'd0);
    cyc("rd_x0",       1, 1, 0,  1, 0,  1, 0,  0, 1, 0,  0,   0, 1, 32'd0);
    cyc("wr_x7_a",     1, 0, 0,  0, 0,  1, 7,  0, 0, 0,  0,   0, 1, 32'd0);
    cyc("wr_x7_b",     1, 0, 0,  0, 0,  1, 7,  0, 0, 0,  0,   0, 1, b(7));
    cyc("wr_x7_c",     1, 0, 0,  0, 0,  1, 7,  0, 0, 0,  0,   0, 1, b(7));
    cyc("wr_x7_sat",   1, 0, 0,  0, 0,  1, 7,  0, 0, 0,  0,   1, 0, b(7));
    cyc("wr_x7_sat_wb",1, 0, 0,  0, 0,  1, 7,  0, 1, 7,  0,   1, 0, b(7));
    cyc("wr_x7_go",    1, 0, 0,  0, 0,  1, 7,  0, 0, 0,  0,   0, 1, b(7));
    cyc("wr_x7_resat", 1, 0, 0,  0, 0,  1, 7,  0, 0, 0,  0,   1, 0, b(7));
    cyc("wb_x7_1",     0, 0, 0,  0, 0,  0, 0,  0, 1, 7,  0,   0, 0, b(7));
    cyc("wb_x7_2",     0, 0, 0,  0, 0,  0, 0,  0, 1, 7,  0,   0, 0, b(7));
    cyc("wb_x7_3",     0, 0, 0,  0, 0,  0, 0,  0, 1, 7,  0,   0, 0, b(7));
    cyc("wr_x9",       1, 0, 0,  0, 0,  1, 9,  0, 0, 0,  0,   0, 1, 32'd0);
    cyc("wr_wb_x9",    1, 0, 0,  0, 0,  1, 9,  0, 1, 9,  0,   0, 1, b(9));
    cyc("x9_held",     0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,   0, 0, b(9));
    cyc("wb_x9",       0, 0, 0,  0, 0,  0, 0,  0, 1, 9,  0,   0, 0, b(9));
    cyc("wr_x3",       1, 0, 0,  0, 0,  1, 3,  0, 0, 0,  0,   0, 1, 32'd0);
    cyc("wr_x4",       1, 0, 0,  0, 0,  1, 4,  0, 0, 0,  0,   0, 1, b(3));
    cyc("wr_x10",      1, 0, 0,  0, 0,  1, 10, 0, 0, 0,  0,   0, 1, b(3) | b(4));
    cyc("flush",       1, 0, 0,  0, 0,  1, 11, 0, 1, 3,  1,   0, 0, b(3) | b(4) | b(10));
    cyc("ext_stall",   1, 0, 0,  0, 0,  1, 12, 1, 0, 0,  0,   1, 0, 32'd0);
    cyc("wr_x12",      1, 0, 0,  0, 0,  1, 12, 0, 0, 0,  0,   0, 1, 32'd0);
    cyc("ext_stall_2", 1, 1, 1,  0, 0,  1, 13, 1, 0, 0,  0,   1, 0, b(12));
    cyc("x13_unch",    0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,   0, 0, b(12));
    cyc("wr_x14",      1, 1, 2,  1, 6,  1, 14, 0, 0, 0,  0,   0, 1, b(12));
    cyc("pre_reset",   0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  0,   0, 0, b(12) | b(14));
    do_reset(1);
    cyc("mid_reset",   1, 1, 12, 1, 14, 1, 14, 0, 0, 0,  0,   0, 1, 32'd0);
    cyc("post_reset",  0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,   0, 0, b(14));

    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rd_scoreboard
